// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - stall/flush scheduler handshake bundle
interface pipe_ctrl_if;
    logic        stallreq_id;
    logic        stallreq_exe;
    logic        imem_req;
    logic        imem_ack;
    logic        dmem_req;
    logic        dmem_ack;
    logic        exc_req;
    logic [31:0] exc_pc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        inst_discard;
    logic        dmem_abort;
    logic        bus_err;

    // Pipeline side: raises requests, consumes stall/flush controls.
    modport master (
        output stallreq_id, stallreq_exe, imem_req, imem_ack,
               dmem_req, dmem_ack, exc_req, exc_pc,
        input  stall, flush, flush_pc, inst_discard, dmem_abort, bus_err
    );

    // Scheduler side.
    modport slave (
        input  stallreq_id, stallreq_exe, imem_req, imem_ack,
               dmem_req, dmem_ack, exc_req, exc_pc,
        output stall, flush, flush_pc, inst_discard, dmem_abort, bus_err
    );
endinterface

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - MiniMIPS32 pipeline stall/flush scheduler with data-bus watchdog
module pipe_ctrl #(
    parameter int DMEM_TIMEOUT = 16
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst_n,
    pipe_ctrl_if.slave  bus
);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [7:0] WCNT_LAST = 8'(DMEM_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  wcnt_q, wcnt_d;

    logic        dmem_wait;
    logic        imem_wait;
    logic [5:0]  stall_req;
    logic [5:0]  stall_c;
    logic        flush_c;
    logic [31:0] flush_pc_c;
    logic        inst_discard_c;
    logic        dmem_abort_c;
    logic        bus_err_c;
    logic        timeout_hit;

    // Priority encode the stall requests: the deepest stalled stage holds itself and everything upstream.
    always_comb begin
        dmem_wait = bus.dmem_req & ~bus.dmem_ack;
        imem_wait = bus.imem_req & ~bus.imem_ack;
        stall_req = 6'b000000;
        if (dmem_wait) begin
            stall_req = 6'b011111;
        end else if (bus.stallreq_exe) begin
            stall_req = 6'b001111;
        end else if (bus.stallreq_id) begin
            stall_req = 6'b000111;
        end else if (imem_wait) begin
            stall_req = 6'b000011;
        end
    end

    // Flush/drain FSM: exceptions flush at once; a fetch in flight at flush time is drained and discarded.
    always_comb begin
        state_d        = state_q;
        flush_c        = 1'b0;
        inst_discard_c = 1'b0;
        stall_c        = stall_req;
        case (state_q)
            RUN: begin
                if (bus.exc_req) begin
                    flush_c        = 1'b1;
                    inst_discard_c = bus.imem_ack;
                    if (imem_wait) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                stall_c = stall_req | 6'b000011;
                flush_c = bus.exc_req;
                if (bus.imem_ack) begin
                    inst_discard_c = 1'b1;
                    state_d        = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
        // A flush empties every pipeline register, so holding any of them is meaningless.
        if (flush_c) begin
            stall_c = 6'b000000;
        end
        flush_pc_c   = flush_c ? bus.exc_pc : 32'h0000_0000;
        dmem_abort_c = flush_c & dmem_wait;
    end

    // Watchdog: count consecutive unacked data-bus wait cycles, fire bus_err on the last allowed one.
    always_comb begin
        timeout_hit = dmem_wait & (wcnt_q == WCNT_LAST);
        bus_err_c   = timeout_hit & ~flush_c;
        if (flush_c | ~dmem_wait | timeout_hit) begin
            wcnt_d = 8'h00;
        end else begin
            wcnt_d = wcnt_q + 8'h01;
        end
    end

    // State and watchdog registers.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q <= RUN;
            wcnt_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Outputs are quiet while reset is held, regardless of the request inputs.
    always_comb begin
        bus.stall        = cpu_rst_n ? stall_c        : 6'b000000;
        bus.flush        = cpu_rst_n & flush_c;
        bus.flush_pc     = cpu_rst_n ? flush_pc_c     : 32'h0000_0000;
        bus.inst_discard = cpu_rst_n & inst_discard_c;
        bus.dmem_abort   = cpu_rst_n & dmem_abort_c;
        bus.bus_err      = cpu_rst_n & bus_err_c;
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl against a behavioural model
module tb_pipe_ctrl;

    logic        clk;
    logic        rst_n;
    logic        stallreq_id, stallreq_exe;
    logic        imem_req, imem_ack, dmem_req, dmem_ack;
    logic        exc_req;
    logic [31:0] exc_pc;

    int errors = 0;
    int checks = 0;

    pipe_ctrl_if if4 ();
    pipe_ctrl_if if8 ();
    pipe_ctrl_if if16 ();

    pipe_ctrl #(.DMEM_TIMEOUT(4))  u_t4  (.cpu_clk_50M(clk), .cpu_rst_n(rst_n), .bus(if4));
    pipe_ctrl #(.DMEM_TIMEOUT(8))  u_t8  (.cpu_clk_50M(clk), .cpu_rst_n(rst_n), .bus(if8));
    pipe_ctrl #(.DMEM_TIMEOUT(16)) u_t16 (.cpu_clk_50M(clk), .cpu_rst_n(rst_n), .bus(if16));

    assign if4.stallreq_id  = stallreq_id;   assign if8.stallreq_id  = stallreq_id;   assign if16.stallreq_id  = stallreq_id;
    assign if4.stallreq_exe = stallreq_exe;  assign if8.stallreq_exe = stallreq_exe;  assign if16.stallreq_exe = stallreq_exe;
    assign if4.imem_req     = imem_req;      assign if8.imem_req     = imem_req;      assign if16.imem_req     = imem_req;
    assign if4.imem_ack     = imem_ack;      assign if8.imem_ack     = imem_ack;      assign if16.imem_ack     = imem_ack;
    assign if4.dmem_req     = dmem_req;      assign if8.dmem_req     = dmem_req;      assign if16.dmem_req     = dmem_req;
    assign if4.dmem_ack     = dmem_ack;      assign if8.dmem_ack     = dmem_ack;      assign if16.dmem_ack     = dmem_ack;
    assign if4.exc_req      = exc_req;       assign if8.exc_req      = exc_req;       assign if16.exc_req      = exc_req;
    assign if4.exc_pc       = exc_pc;        assign if8.exc_pc       = exc_pc;        assign if16.exc_pc       = exc_pc;

    logic [5:0]  o_stall [3];
    logic        o_flush [3];
    logic [31:0] o_fpc   [3];
    logic        o_disc  [3];
    logic        o_abort [3];
    logic        o_berr  [3];

    assign o_stall[0] = if4.stall;        assign o_stall[1] = if8.stall;        assign o_stall[2] = if16.stall;
    assign o_flush[0] = if4.flush;        assign o_flush[1] = if8.flush;        assign o_flush[2] = if16.flush;
    assign o_fpc[0]   = if4.flush_pc;     assign o_fpc[1]   = if8.flush_pc;     assign o_fpc[2]   = if16.flush_pc;
    assign o_disc[0]  = if4.inst_discard; assign o_disc[1]  = if8.inst_discard; assign o_disc[2]  = if16.inst_discard;
    assign o_abort[0] = if4.dmem_abort;   assign o_abort[1] = if8.dmem_abort;   assign o_abort[2] = if16.dmem_abort;
    assign o_berr[0]  = if4.bus_err;      assign o_berr[1]  = if8.bus_err;      assign o_berr[2]  = if16.bus_err;

    int tmo [3] = '{4, 8, 16};

    // Reference model state: draining flag and length of the current unacked data wait per timeout.
    bit m_drain;
    int m_run [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Evaluate the model for the current inputs at the falling edge, compare all DUTs, then advance one clock.
    task automatic run_cycle();
        bit         dwait, iwait;
        int         s;
        logic [5:0] e_stall;
        bit         e_flush, e_disc, e_abort, e_berr;
        @(negedge clk);
        dwait = dmem_req && !dmem_ack;
        iwait = imem_req && !imem_ack;
        if (dwait)             s = 4;
        else if (stallreq_exe) s = 3;
        else if (stallreq_id)  s = 2;
        else if (iwait)        s = 1;
        else                   s = -1;
        e_stall = 6'((1 << (s + 1)) - 1);
        if (m_drain) e_stall = e_stall | 6'b000011;
        e_flush = exc_req;
        if (e_flush) e_stall = 6'b000000;
        e_abort = exc_req && dwait;
        e_disc  = m_drain ? imem_ack : (exc_req && imem_ack);
        for (int k = 0; k < 3; k++) begin
            e_berr = !exc_req && dwait && ((m_run[k] + 1) % tmo[k] == 0);
            if (!rst_n) begin
                e_stall = 6'b000000; e_flush = 1'b0; e_disc = 1'b0; e_abort = 1'b0; e_berr = 1'b0;
            end
            check($sformatf("stall_t%0d", tmo[k]),   32'(o_stall[k]), 32'(e_stall));
            check($sformatf("flush_t%0d", tmo[k]),   32'(o_flush[k]), 32'(e_flush));
            if (e_flush) check($sformatf("flush_pc_t%0d", tmo[k]), o_fpc[k], exc_pc);
            check($sformatf("discard_t%0d", tmo[k]), 32'(o_disc[k]),  32'(e_disc));
            check($sformatf("abort_t%0d", tmo[k]),   32'(o_abort[k]), 32'(e_abort));
            check($sformatf("bus_err_t%0d", tmo[k]), 32'(o_berr[k]),  32'(e_berr));
        end
        if (!rst_n) begin
            m_drain = 1'b0;
            for (int k = 0; k < 3; k++) m_run[k] = 0;
        end else begin
            m_drain = m_drain ? !imem_ack : (exc_req && iwait);
            for (int k = 0; k < 3; k++) m_run[k] = (exc_req || !dwait) ? 0 : m_run[k] + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stallreq_id = 0; stallreq_exe = 0; imem_req = 0; imem_ack = 0;
        dmem_req = 0; dmem_ack = 0; exc_req = 0; exc_pc = 32'h0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        m_drain = 1'b0;
        for (int k = 0; k < 3; k++) m_run[k] = 0;

        // Reset: outputs quiet even with requests present.
        stallreq_id = 1; dmem_req = 1; exc_req = 1; exc_pc = 32'h1234_5678;
        run_cycle();
        check("rst_stall", 32'(if16.stall), 32'h0);
        check("rst_flush", 32'(if16.flush), 32'h0);
        run_cycle();
        rst_n = 1'b1;
        idle_inputs();
        run_cycle();

        // Load-use only, then with divider busy.
        stallreq_id = 1; #1;
        check("tp_id_stall", 32'(if16.stall), 32'h07);
        run_cycle();
        stallreq_exe = 1; #1;
        check("tp_exe_stall", 32'(if16.stall), 32'h0f);
        run_cycle();
        idle_inputs();
        run_cycle();

        // Data access acked after 3 wait cycles.
        dmem_req = 1;
        for (int i = 0; i < 3; i++) begin
            #1 check("tp_dwait_stall", 32'(if16.stall), 32'h1f);
            run_cycle();
        end
        dmem_ack = 1; #1;
        check("tp_dack_stall", 32'(if16.stall), 32'h0);
        run_cycle();
        idle_inputs();
        run_cycle();

        // Hung access: T=4 pulses bus_err in wait cycle 4 only, then exception aborts it.
        dmem_req = 1;
        for (int i = 1; i <= 6; i++) begin
            #1 check("tp_berr_t4", 32'(if4.bus_err), 32'(i == 4));
            run_cycle();
        end
        exc_req = 1; exc_pc = 32'hBFC0_0380; #1;
        check("tp_exc_flush", 32'(if4.flush), 32'h1);
        check("tp_exc_pc", if4.flush_pc, 32'hBFC0_0380);
        check("tp_exc_abort", 32'(if4.dmem_abort), 32'h1);
        check("tp_exc_stall", 32'(if4.stall), 32'h0);
        run_cycle();
        idle_inputs();
        run_cycle();

        // Exception with a fetch in flight: drain, discard on ack.
        exc_req = 1; exc_pc = 32'h8000_0180; imem_req = 1;
        run_cycle();
        exc_req = 0; #1;
        check("tp_drain_stall", 32'(if16.stall), 32'h03);
        run_cycle();
        run_cycle();
        imem_ack = 1; #1;
        check("tp_drain_discard", 32'(if16.inst_discard), 32'h1);
        run_cycle();
        idle_inputs(); #1;
        check("tp_back_run_stall", 32'(if16.stall), 32'h0);
        run_cycle();

        // Exception and data ack together with divider busy.
        stallreq_exe = 1; dmem_req = 1; dmem_ack = 1; exc_req = 1; exc_pc = 32'hBFC0_0200; #1;
        check("tp_exc_ack_abort", 32'(if16.dmem_abort), 32'h0);
        check("tp_exc_ack_stall", 32'(if16.stall), 32'h0);
        run_cycle();
        idle_inputs();
        run_cycle();

        // Reset in DRAIN and mid-watchdog count.
        exc_req = 1; imem_req = 1;
        run_cycle();
        exc_req = 0; dmem_req = 1;
        run_cycle(); run_cycle(); run_cycle();
        rst_n = 1'b0; #1;
        check("tp_rst_drain_stall", 32'(if8.stall), 32'h0);
        check("tp_rst_drain_berr", 32'(if4.bus_err), 32'h0);
        run_cycle();
        rst_n = 1'b1;
        idle_inputs();
        dmem_req = 1;
        for (int i = 0; i < 4; i++) begin
            #1 check("tp_post_rst_berr_t8", 32'(if8.bus_err), 32'h0);
            run_cycle();
        end
        dmem_ack = 1;
        run_cycle();
        idle_inputs();
        run_cycle();

        // Randomized traffic.
        for (int n = 0; n < 800; n++) begin
            bit prev_hold;
            prev_hold    = dmem_req && !dmem_ack;
            rst_n        = ($urandom % 100) != 0;
            stallreq_id  = ($urandom % 4) == 0;
            stallreq_exe = ($urandom % 5) == 0;
            imem_req     = ($urandom % 2) == 0;
            imem_ack     = ($urandom % 3) == 0;
            dmem_req     = prev_hold ? 1'b1 : (($urandom % 3) != 0);
            dmem_ack     = ($urandom % 7) == 0;
            exc_req      = ($urandom % 20) == 0;
            exc_pc       = $urandom;
            run_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
